// File: rtl/gpu_cfg_pkg.sv
// Shared definitions for the GPU configuration shell: register offsets,
// the ID constant, STATUS bit positions, the DMA descriptor type and the
// byte-length to beat-count conversion.
package gpu_cfg_pkg;

  localparam logic [7:0] OFF_ID         = 8'h00;
  localparam logic [7:0] OFF_SCRATCH    = 8'h04;
  localparam logic [7:0] OFF_SRC_LO     = 8'h10;
  localparam logic [7:0] OFF_SRC_HI     = 8'h14;
  localparam logic [7:0] OFF_DST_LO     = 8'h18;
  localparam logic [7:0] OFF_DST_HI     = 8'h1C;
  localparam logic [7:0] OFF_LEN        = 8'h20;
  localparam logic [7:0] OFF_START      = 8'h24;
  localparam logic [7:0] OFF_BEATS_LEFT = 8'h28;
  localparam logic [7:0] OFF_STATUS     = 8'h2C;

  localparam logic [31:0] GPU_ID = 32'h4F47_5055;

  localparam int STATUS_DONE_BIT = 0;
  localparam int STATUS_BUSY_BIT = 1;

  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dst;
    logic [31:0] len;
  } dma_desc_t;

  // Round a byte length up to 32-bit beats; the 33-bit sum keeps
  // 0xFFFF_FFFF from wrapping to zero.
  function automatic logic [31:0] len_to_beats(input logic [31:0] len);
    logic [32:0] sum;
    sum = {1'b0, len} + 33'd3;
    return {1'b0, sum[32:2]};
  endfunction

endpackage

// File: rtl/gpu_dma_engine.sv
// DMA descriptor engine: latches a descriptor on an accepted start, counts
// down one 32-bit beat per cycle while advancing working addresses, and
// reports busy plus a sticky done flag.
module gpu_dma_engine
  import gpu_cfg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  dma_desc_t   desc_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] beats_left_o
);

  logic        busy_q;
  logic        done_q;
  logic        zero_pend_q;
  logic [31:0] beats_q;
  logic [63:0] src_q;
  logic [63:0] dst_q;
  logic [31:0] launch_beats;
  logic        accept;

  assign launch_beats = len_to_beats(desc_i.len);
  // A start arriving while a transfer runs is dropped.
  assign accept       = start_i && !busy_q;

  // Launch, per-beat countdown/address advance, and completion flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      zero_pend_q <= 1'b0;
      beats_q     <= '0;
      src_q       <= '0;
      dst_q       <= '0;
    end else if (accept) begin
      src_q       <= desc_i.src;
      dst_q       <= desc_i.dst;
      beats_q     <= launch_beats;
      busy_q      <= (launch_beats != 32'd0);
      // Zero-length launches never go busy; done follows one cycle later.
      zero_pend_q <= (launch_beats == 32'd0);
      done_q      <= 1'b0;
    end else begin
      if (zero_pend_q) begin
        zero_pend_q <= 1'b0;
        done_q      <= 1'b1;
      end
      if (busy_q) begin
        beats_q <= beats_q - 32'd1;
        src_q   <= src_q + 64'd4;
        dst_q   <= dst_q + 64'd4;
        if (beats_q == 32'd1) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign beats_left_o = beats_q;

endmodule

// File: rtl/gpu_top.sv
// GPU shell: single-cycle configuration port with address decode, the
// descriptor register file and the read mux, driving gpu_dma_engine.
// Optional build macro: GPU_CFG_READBACK_EN makes the descriptor registers
// (0x10-0x20) readable; without it they read 0 but still program launches.
module gpu_top
  import gpu_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_req_valid,
  input  logic [31:0] cfg_req_addr,
  input  logic [31:0] cfg_req_wdata,
  output logic        cfg_resp_valid,
  output logic [31:0] cfg_resp_rdata
);

  logic [7:0]  off;
  logic        unused_addr_bits;
  logic [31:0] scratch_q;
  logic [31:0] src_lo_q, src_hi_q, dst_lo_q, dst_hi_q, len_q;
  logic        start_req;
  dma_desc_t   desc;
  logic        busy, done;
  logic [31:0] beats_left;
  logic [31:0] rdata;

  // Only address bits [7:2] select a register.
  assign off              = {cfg_req_addr[7:2], 2'b00};
  assign unused_addr_bits = ^{cfg_req_addr[31:8], cfg_req_addr[1:0]};
  assign start_req        = cfg_req_valid && (off == OFF_START) && cfg_req_wdata[0];

  assign desc.src = {src_hi_q, src_lo_q};
  assign desc.dst = {dst_hi_q, dst_lo_q};
  assign desc.len = len_q;

  // Register file writes; read-only and unmapped offsets ignore writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q <= '0;
      src_lo_q  <= '0;
      src_hi_q  <= '0;
      dst_lo_q  <= '0;
      dst_hi_q  <= '0;
      len_q     <= '0;
    end else if (cfg_req_valid) begin
      case (off)
        OFF_SCRATCH: scratch_q <= cfg_req_wdata;
        OFF_SRC_LO:  src_lo_q  <= cfg_req_wdata;
        OFF_SRC_HI:  src_hi_q  <= cfg_req_wdata;
        OFF_DST_LO:  dst_lo_q  <= cfg_req_wdata;
        OFF_DST_HI:  dst_hi_q  <= cfg_req_wdata;
        OFF_LEN:     len_q     <= cfg_req_wdata;
        default: ;
      endcase
    end
  end

  gpu_dma_engine u_engine (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start_req),
    .desc_i       (desc),
    .busy_o       (busy),
    .done_o       (done),
    .beats_left_o (beats_left)
  );

  // Combinational read mux from current register state.
  always_comb begin
    rdata = '0;
    if (cfg_req_valid) begin
      case (off)
        OFF_ID:         rdata = GPU_ID;
        OFF_SCRATCH:    rdata = scratch_q;
`ifdef GPU_CFG_READBACK_EN
        OFF_SRC_LO:     rdata = src_lo_q;
        OFF_SRC_HI:     rdata = src_hi_q;
        OFF_DST_LO:     rdata = dst_lo_q;
        OFF_DST_HI:     rdata = dst_hi_q;
        OFF_LEN:        rdata = len_q;
`endif
        OFF_BEATS_LEFT: rdata = beats_left;
        OFF_STATUS: begin
          rdata[STATUS_DONE_BIT] = done;
          rdata[STATUS_BUSY_BIT] = busy;
        end
        default:        rdata = '0;
      endcase
    end
  end

  assign cfg_resp_valid = cfg_req_valid;
  assign cfg_resp_rdata = rdata;

endmodule

// File: tb/tb_gpu_top.sv
// Bench for gpu_top: a time-based behavioural model (launch cycle + beat
// count) checked against the DUT on every falling edge, directed sequences
// with literal expectations, then randomized register traffic.
module tb_gpu_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_req_valid = 1'b0;
  logic [31:0] cfg_req_addr = '0;
  logic [31:0] cfg_req_wdata = '0;
  logic        cfg_resp_valid;
  logic [31:0] cfg_resp_rdata;

  int total = 0;
  int bad   = 0;

  gpu_top dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_req_valid  (cfg_req_valid),
    .cfg_req_addr   (cfg_req_addr),
    .cfg_req_wdata  (cfg_req_wdata),
    .cfg_resp_valid (cfg_resp_valid),
    .cfg_resp_rdata (cfg_resp_rdata)
  );

  always #5 clk = ~clk;

`ifdef GPU_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  // ---------------- behavioural model ----------------
  logic [31:0] m_scratch = '0, m_src_lo = '0, m_src_hi = '0;
  logic [31:0] m_dst_lo = '0, m_dst_hi = '0, m_len = '0;
  longint      m_cyc = 0, m_launch = 0, m_beats = 0;
  bit          m_launched = 1'b0;

  function automatic longint m_n();
    return m_cyc - m_launch;
  endfunction

  function automatic bit m_busy();
    return m_launched && (m_beats != 0) && (m_n() < m_beats);
  endfunction

  function automatic bit m_done();
    if (!m_launched) return 1'b0;
    if (m_beats == 0) return m_n() >= 1;
    return m_n() >= m_beats;
  endfunction

  function automatic logic [31:0] m_left();
    longint r;
    r = m_busy() ? (m_beats - m_n()) : 0;
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_read(input logic v, input logic [31:0] a);
    logic [5:0] w;
    w = a[7:2];
    if (!v) return 32'h0;
    case (w)
      6'h00: return 32'h4F47_5055;
      6'h01: return m_scratch;
      6'h04: return RB ? m_src_lo : 32'h0;
      6'h05: return RB ? m_src_hi : 32'h0;
      6'h06: return RB ? m_dst_lo : 32'h0;
      6'h07: return RB ? m_dst_hi : 32'h0;
      6'h08: return RB ? m_len : 32'h0;
      6'h0A: return m_left();
      6'h0B: return {30'h0, m_busy(), m_done()};
      default: return 32'h0;
    endcase
  endfunction

  // Model state advances on each rising edge; reset wipes it at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_scratch <= '0; m_src_lo <= '0; m_src_hi <= '0;
      m_dst_lo <= '0; m_dst_hi <= '0; m_len <= '0;
      m_cyc <= 0; m_launch <= 0; m_beats <= 0; m_launched <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (cfg_req_valid) begin
        case (cfg_req_addr[7:2])
          6'h01: m_scratch <= cfg_req_wdata;
          6'h04: m_src_lo  <= cfg_req_wdata;
          6'h05: m_src_hi  <= cfg_req_wdata;
          6'h06: m_dst_lo  <= cfg_req_wdata;
          6'h07: m_dst_hi  <= cfg_req_wdata;
          6'h08: m_len     <= cfg_req_wdata;
          default: ;
        endcase
        if (cfg_req_addr[7:2] == 6'h09 && cfg_req_wdata[0] && !m_busy()) begin
          m_launched <= 1'b1;
          m_launch   <= m_cyc + 1;
          m_beats    <= (longint'(m_len) + 3) / 4;
        end
      end
    end
  end

  // Every cycle: response must mirror the request and match the model.
  always @(negedge clk) begin
    logic [31:0] exp;
    exp = m_read(cfg_req_valid, cfg_req_addr);
    total++;
    if (cfg_resp_valid !== cfg_req_valid || cfg_resp_rdata !== exp) begin
      bad++;
      $display("FAIL model_cmp addr=%h valid=%b/%b got=%h exp=%h", cfg_req_addr,
               cfg_resp_valid, cfg_req_valid, cfg_resp_rdata, exp);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] w,
                     input bit chk, input logic [31:0] exp, input string nm,
                     output logic [31:0] got);
    cfg_req_valid = v;
    cfg_req_addr  = a;
    cfg_req_wdata = w;
    @(negedge clk);
    got = cfg_resp_rdata;
    if (chk) begin
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] g;
    cyc(1'b1, a, w, 1'b0, 32'h0, "", g);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] g;
    cyc(1'b1, a, 32'h0, 1'b1, exp, nm, g);
  endtask

  task automatic idle();
    logic [31:0] g;
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, "idle_rdata", g);
  endtask

  logic [7:0] offs [13] = '{8'h00, 8'h04, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20,
                            8'h24, 8'h28, 8'h2C, 8'h30, 8'h3C, 8'hFC};

  initial begin
    logic [31:0] g, r, a, w;
    int i;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    rd(32'h00, 32'h4F47_5055, "id");
    rd(32'h2C, 32'h0, "status_reset");
    rd(32'h28, 32'h0, "beats_reset");
    idle();

    // LEN=16 transfer: busy for 4 cycles then done
    wr(32'h10, 32'h1000);
    wr(32'h18, 32'h2000);
    wr(32'h20, 32'd16);
    wr(32'h24, 32'h1);
    rd(32'h2C, 32'h2, "len16_busy0");
    rd(32'h2C, 32'h2, "len16_busy1");
    rd(32'h2C, 32'h2, "len16_busy2");
    rd(32'h2C, 32'h2, "len16_busy3");
    rd(32'h2C, 32'h1, "len16_done");
    // same descriptor again: BEATS_LEFT counts 4..0
    wr(32'h24, 32'h1);
    rd(32'h28, 32'd4, "beats4");
    rd(32'h28, 32'd3, "beats3");
    rd(32'h28, 32'd2, "beats2");
    rd(32'h28, 32'd1, "beats1");
    rd(32'h28, 32'd0, "beats0");

    // LEN=0: never busy, done one cycle after accept
    wr(32'h20, 32'd0);
    wr(32'h24, 32'h1);
    rd(32'h2C, 32'h0, "len0_accept");
    rd(32'h2C, 32'h1, "len0_done");

    // LEN=64 with a second start while busy
    wr(32'h20, 32'd64);
    wr(32'h24, 32'h1);
    rd(32'h2C, 32'h2, "len64_busy");
    wr(32'h24, 32'h1);
    rd(32'h28, 32'd14, "len64_beats_after_restart");
    i = 0;
    g = 32'h0;
    while (i < 200) begin
      cyc(1'b1, 32'h2C, 32'h0, 1'b0, 32'h0, "", g);
      if (g == 32'h1) break;
      i++;
    end
    total++;
    if (g != 32'h1 || i != 13) begin
      bad++;
      $display("FAIL len64_latency got_polls=%0d status=%h exp_polls=13 status=1", i, g);
    end

    // reset mid-transfer with BEATS_LEFT=3
    wr(32'h20, 32'd16);
    wr(32'h24, 32'h1);
    rd(32'h28, 32'd4, "pre_reset_beats");
    rst_n = 1'b0;
    rd(32'h2C, 32'h0, "reset_status");
    rd(32'h28, 32'h0, "reset_beats");
    rst_n = 1'b1;
    rd(32'h04, 32'h0, "reset_scratch");
    wr(32'h20, 32'd4);
    wr(32'h24, 32'h1);
    rd(32'h2C, 32'h2, "len4_busy");
    rd(32'h2C, 32'h1, "len4_done");

    // readback and side-effect-free writes
    wr(32'h20, 32'h55);
    rd(32'h20, RB ? 32'h55 : 32'h0, "len_readback");
    wr(32'h2C, 32'hFFFF_FFFF);
    rd(32'h2C, 32'h1, "status_wr_ignored");
    wr(32'h24, 32'hFFFF_FFFE);
    rd(32'h2C, 32'h1, "start_bit0_clear");
    wr(32'h00, 32'h0);
    rd(32'hABCD_0003, 32'h4F47_5055, "id_alias");
    wr(32'hFF00_0006, 32'hDEAD_BEEF);
    rd(32'h04, 32'hDEAD_BEEF, "scratch_alias");
    rd(32'h30, 32'h0, "unmapped");

    // randomized traffic, model-checked every cycle
    for (int k = 0; k < 3000; k++) begin
      r = $urandom();
      a = $urandom();
      w = $urandom();
      a[7:0] = offs[$urandom_range(0, 12)];
      a[1:0] = r[1:0];
      if (a[7:2] == 6'h08) w = $urandom_range(0, 40);
      if (r[20:12] == 9'd0) begin
        rst_n = 1'b0;
        cyc(1'b1, a, 32'h0, 1'b0, 32'h0, "", g);
        rst_n = 1'b1;
      end else begin
        cyc(r[3:2] != 2'b00, a, w, 1'b0, 32'h0, "", g);
      end
    end

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
